// File: rtl/register_write_arbiter.sv
// register_write_arbiter: a round-robin arbiter in front of one shared WIDTH-bit register.
// Each cycle at most one requester gets a grant. The granted requester's data is loaded on the next edge.
// The block also reports which requester performed the last write, and pulses wr_pulse after each write.
// Optional feature: define REG_ARB_LOCK_EN to let a granted requester keep the grant for a while.
// The hold lasts up to 8 consecutive grants.
module register_write_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  input  logic [NUM_REQ-1:0]       lock,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         out,
  output logic                     out_valid,
  output logic [IDX_W-1:0]         owner,
  output logic                     wr_pulse
);

  logic [WIDTH-1:0] wdata_arr [NUM_REQ];
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] rr_winner;
  logic             rr_found;
  logic [IDX_W-1:0] winner;
  logic             grant_any;

  // Successor of a requester index, wrapping from NUM_REQ-1 back to 0.
  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign wdata_arr[i] = wdata[i*WIDTH +: WIDTH];
  end

  // Round-robin search: the first requesting index at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    // NOTE: every variable gets a default before the search loop, so no latch is inferred.
    rr_found  = 1'b0;
    rr_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [IDX_W-1:0] idx;
      idx = (int'(ptr) + k >= NUM_REQ) ? IDX_W'(int'(ptr) + k - NUM_REQ) : IDX_W'(int'(ptr) + k);
      if (!rr_found && req[idx]) begin
        rr_found  = 1'b1;
        rr_winner = idx;
      end
    end
  end

`ifdef REG_ARB_LOCK_EN
  localparam logic       ST_ARB    = 1'b0;
  localparam logic       ST_LOCKED = 1'b1;
  localparam logic [3:0] LOCK_CAP  = 4'd8;

  logic             state;
  logic [IDX_W-1:0] lock_w;
  logic [3:0]       lock_cnt;
  logic             lock_exit;

  // While locked, only the lock holder can be granted, and only while it keeps requesting.
  always_comb begin
    winner    = rr_winner;
    grant_any = rr_found;
    if (state == ST_LOCKED) begin
      winner    = lock_w;
      grant_any = req[lock_w];
    end
  end

  // The lock ends when the holder drops lock or req, or when this grant would bring the count to the cap.
  assign lock_exit = !lock[lock_w] || !req[lock_w] || (lock_cnt + 4'd1 == LOCK_CAP);

  // Arbitration state, pointer and lock bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ARB;
      ptr      <= '0;
      lock_w   <= '0;
      lock_cnt <= '0;
    end else if (state == ST_ARB) begin
      if (grant_any) begin
        if (lock[winner]) begin
          // The pointer stays put on entry. It moves past the holder when the lock is released.
          state    <= ST_LOCKED;
          lock_w   <= winner;
          lock_cnt <= 4'd1;
        end else begin
          ptr <= inc_wrap(winner);
        end
      end
    end else begin
      if (lock_exit) begin
        state    <= ST_ARB;
        ptr      <= inc_wrap(lock_w);
        lock_cnt <= '0;
      end else begin
        lock_cnt <= lock_cnt + 4'd1;
      end
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign winner      = rr_winner;
  assign grant_any   = rr_found;

  // Pointer moves one past each winner, so a requester that was just served goes to the back of the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_any) begin
      // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
      ptr <= inc_wrap(winner);
    end
  end
`endif

  // One-hot grant. It is forced low while reset is asserted.
  always_comb begin
    gnt = '0;
    if (rst_n && grant_any) gnt[winner] = 1'b1;
  end

  // Shared register write: load the granted data, record the writer, and flag the write for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      owner     <= '0;
      wr_pulse  <= 1'b0;
    end else begin
      wr_pulse <= grant_any;
      if (grant_any) begin
        out       <= wdata_arr[winner];
        owner     <= winner;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_register_write_arbiter.sv
// Testbench for register_write_arbiter (NUM_REQ=4, WIDTH=8).
// A driver applies stimulus and advances a behavioural model. The model pushes the expected grant and write into queues.
// A monitor pops those queues and compares them with the DUT outputs.
module tb_register_write_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
`ifdef REG_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct { int tag; logic [3:0] g; } gnt_exp_t;
  typedef struct { int due; logic [7:0] data; logic [1:0] owner; } wr_exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req;
  logic [31:0]     wdata;
  logic [3:0]      lock;
  logic [3:0]      gnt;
  logic [7:0]      out;
  logic            out_valid;
  logic [1:0]      owner;
  logic            wr_pulse;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit in_reset;

  gnt_exp_t gnt_q[$];
  wr_exp_t  wr_q[$];

  // Model state: the pointer, the lock holder and the lock grant count.
  int m_ptr, m_lw, m_cnt;
  bit m_locked;
  // Register contents the monitor expects while no write is arriving.
  logic [7:0] hold_out;
  logic [1:0] hold_owner;
  logic       hold_valid;

  register_write_arbiter #(.WIDTH(W), .NUM_REQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .lock(lock),
    .gnt(gnt), .out(out), .out_valid(out_valid), .owner(owner), .wr_pulse(wr_pulse)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_lw = 0; m_cnt = 0; m_locked = 1'b0;
    hold_out = '0; hold_owner = '0; hold_valid = 1'b0;
    gnt_q.delete();
    wr_q.delete();
  endtask

  // Apply one cycle of stimulus and advance the model through the edge that ends this cycle.
  task automatic drive(input logic [3:0] r, input logic [31:0] d, input logic [3:0] l);
    int g;
    logic [3:0] gv;
    gnt_exp_t ge;
    wr_exp_t we;
    @(negedge clk);
    req = r; wdata = d; lock = l;
    g = -1;
    if (m_locked) begin
      if (r[m_lw]) g = m_lw;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (g < 0 && r[i]) g = i;
      end
    end
    gv = '0;
    if (g >= 0) gv[g] = 1'b1;
    ge.tag = cyc; ge.g = gv;
    gnt_q.push_back(ge);
    if (g >= 0) begin
      we.due = cyc + 1; we.data = d[g*8 +: 8]; we.owner = 2'(g);
      wr_q.push_back(we);
    end
    if (m_locked) begin
      if (r[m_lw]) m_cnt++;
      if (!l[m_lw] || !r[m_lw] || m_cnt >= 8) begin
        m_locked = 1'b0;
        m_ptr = (m_lw + 1) % NREQ;
      end
    end else if (g >= 0) begin
      if (LOCK_EN && l[g]) begin
        m_locked = 1'b1; m_lw = g; m_cnt = 1;
      end else begin
        m_ptr = (g + 1) % NREQ;
      end
    end
  endtask

  // Monitor: 2 time units after each falling edge, compare gnt and the register outputs with the queued expectations.
  initial begin
    gnt_exp_t ge;
    wr_exp_t  we;
    forever begin
      @(negedge clk);
      #2;
      if (!in_reset) begin
        if (gnt_q.size() > 0 && gnt_q[0].tag == cyc) begin
          ge = gnt_q.pop_front();
          check("gnt", 32'(gnt), 32'(ge.g));
        end
        while (wr_q.size() > 0 && wr_q[0].due < cyc) begin
          we = wr_q.pop_front();
          check("write_missed", 32'(0), 32'(1));
        end
        if (wr_q.size() > 0 && wr_q[0].due == cyc) begin
          we = wr_q.pop_front();
          check("wr_pulse", 32'(wr_pulse), 32'(1));
          hold_out = we.data; hold_owner = we.owner; hold_valid = 1'b1;
        end else begin
          check("wr_pulse", 32'(wr_pulse), 32'(0));
        end
        check("out", 32'(out), 32'(hold_out));
        check("owner", 32'(owner), 32'(hold_owner));
        check("out_valid", 32'(out_valid), 32'(hold_valid));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse reset between edges while the register holds data. The reset must clear it immediately.
  task automatic mid_reset();
    @(negedge clk);
    req = '0; lock = '0;
    #4;
    rst_n = 1'b0;
    #1;
    check("mid_reset_out", 32'(out), 32'(0));
    check("mid_reset_owner", 32'(owner), 32'(0));
    check("mid_reset_valid", 32'(out_valid), 32'(0));
    check("mid_reset_wr_pulse", 32'(wr_pulse), 32'(0));
    check("mid_reset_gnt", 32'(gnt), 32'(0));
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] lk;
    in_reset = 1'b1;
    rst_n = 1'b0; req = 4'hF; wdata = 32'h13121110; lock = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("reset_gnt", 32'(gnt), 32'(0));
    check("reset_out", 32'(out), 32'(0));
    check("reset_valid", 32'(out_valid), 32'(0));
    check("reset_wr_pulse", 32'(wr_pulse), 32'(0));
    check("reset_owner", 32'(owner), 32'(0));
    @(negedge clk);
    req = '0; rst_n = 1'b1; in_reset = 1'b0;

    // First grant after reset goes to requester 0.
    drive(4'hF, 32'h13121110, 4'h0);
    drive(4'h0, 32'h0, 4'h0);
    // Single requester 2 with A5. Idle cycles follow so wr_pulse is seen dropping.
    drive(4'b0100, 32'h00A50000, 4'h0);
    drive(4'h0, 32'h0, 4'h0);
    drive(4'h0, 32'h0, 4'h0);
    // Skip and wrap: the pointer is 3 and only requesters 0 and 1 request.
    drive(4'b0011, 32'h44332211, 4'h0);
    drive(4'b0011, 32'h44332211, 4'h0);
    // Requester 3 moves the pointer to 0, then all four request for six cycles.
    drive(4'b1000, 32'h77000000, 4'h0);
    repeat (6) drive(4'hF, 32'h13121110, 4'h0);
    // Load 13 from requester 3, then reset between edges.
    drive(4'b1000, 32'h13000000, 4'h0);
    drive(4'h0, 32'h0, 4'h0);
    mid_reset();
    drive(4'hF, 32'h13121110, 4'h0);
    // Lock scenario: the pointer is 1, all four request, and requester 1 holds lock.
    repeat (12) drive(4'hF, 32'h13121110, 4'b0010);
    drive(4'h0, 32'h0, 4'h0);

    // Random traffic with lock bits that change only occasionally.
    lk = '0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) lk = 4'($urandom);
      drive(($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom), $urandom, lk);
    end
    drive(4'h0, 32'h0, 4'h0);
    drive(4'h0, 32'h0, 4'h0);
    @(negedge clk);
    #3;
    check("queues_drained", 32'(gnt_q.size() + wr_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
